// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds it for
// LATENCY cycles, then returns a one-cycle response with lane-extracted,
// extended read data or an error flag. busy is the pipeline stall source.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; req_ready = 1
// S_WAIT | request latched, counting down the remaining wait cycles
// S_RESP | response cycle; resp_valid = 1, rdata/err stable
module data_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_mode;

    logic [31:0] mem [DEPTH];

    // With LATENCY = 1 the commit edge is the accept edge, so the request is
    // taken straight from the inputs; otherwise from the latched copy.
    logic        eff_write;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [2:0]  eff_mode;
    logic [1:0]  eff_size;
    logic [ADDR_BITS-1:0] word_idx;

    logic        commit;
    logic        err_c;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    assign eff_write = (state == S_IDLE) ? req_write : lat_write;
    assign eff_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign eff_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign eff_mode  = (state == S_IDLE) ? req_mode  : lat_mode;
    assign eff_size  = eff_mode[1:0];
    assign word_idx  = eff_addr[ADDR_BITS+1:2];

    assign commit = (state_nxt == S_RESP) && (state != S_RESP);

    // Error decode, store lane enables and load lane extraction
    always_comb begin
        err_c = (eff_size == 2'd3)
             || ((eff_size == 2'd1) && eff_addr[0])
             || ((eff_size == 2'd2) && (eff_addr[1:0] != 2'd0))
             || (|eff_addr[31:ADDR_BITS+2]);

        byte_en = 4'b0000;
        wr_data = 32'd0;
        case (eff_size)
            2'd0: begin
                byte_en = 4'b0001 << eff_addr[1:0];
                wr_data = {4{eff_wdata[7:0]}};
            end
            2'd1: begin
                byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{eff_wdata[15:0]}};
            end
            2'd2: begin
                byte_en = 4'b1111;
                wr_data = eff_wdata;
            end
            default: ;
        endcase

        rd_word = mem[word_idx];
        case (eff_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (eff_size)
            2'd0:    load_val = eff_mode[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    load_val = eff_mode[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // State, countdown, request latch and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_mode   <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_mode  <= req_mode;
            end
            if (commit) begin
                resp_rdata <= (!eff_write && !err_c) ? load_val : 32'd0;
                resp_err   <= err_c;
            end else begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    // Array write on the commit edge; reset on that edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && commit && eff_write && !err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // Next-state and countdown
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready  = (state == S_IDLE);
        busy       = (state != S_IDLE);
        resp_valid = (state == S_RESP);
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances with LATENCY 1..4 share the
// request fields; each has its own req_valid. A byte-addressed reference
// memory per instance predicts load data and errors.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;

    logic        req_valid_v  [4];
    logic        req_ready_v  [4];
    logic        resp_valid_v [4];
    logic [31:0] resp_rdata_v [4];
    logic        resp_err_v   [4];
    logic        busy_v       [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            data_mem_responder #(.ADDR_BITS(10), .LATENCY(g + 1)) u_dut (
                .clk        (clk),
                .reset      (reset),
                .req_valid  (req_valid_v[g]),
                .req_ready  (req_ready_v[g]),
                .req_write  (req_write),
                .req_addr   (req_addr),
                .req_wdata  (req_wdata),
                .req_mode   (req_mode),
                .resp_valid (resp_valid_v[g]),
                .resp_rdata (resp_rdata_v[g]),
                .resp_err   (resp_err_v[g]),
                .busy       (busy_v[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // reference memory: bytes 0..255 of each instance
    logic [7:0] mb [4][256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int inst, input bit w, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] m,
                                  output bit e, output logic [31:0] rd);
        int n;
        int sh;
        logic [31:0] v;
        logic signed [31:0] sv;
        n  = 1 << m[1:0];
        e  = (m[1:0] == 2'd3) || (a >= 32'h1000) || ((a % n) != 0);
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[inst][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[inst][int'(a) + i]) << (8 * i));
                if (n < 4 && !m[2]) begin
                    sh = 32 - 8 * n;
                    sv = v << sh;
                    sv = sv >>> sh;
                    v  = sv;
                end
                rd = v;
            end
        end
    endfunction

    // One complete request on instance inst, checked against the model
    task automatic do_req(input int inst, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] m,
                          output logic [31:0] got_rd, output bit got_e);
        int lat;
        bit e_exp;
        logic [31:0] rd_exp;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready_v[inst]), 32'd1);
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_mode  = m;
        req_valid_v[inst] = 1'b1;
        @(posedge clk);
        #1 req_valid_v[inst] = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("busy", 32'(busy_v[inst]), 32'd1);
            chk("ready_low", 32'(req_ready_v[inst]), 32'd0);
            if (resp_valid_v[inst]) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(inst + 1));
        model(inst, w, a, wd, m, e_exp, rd_exp);
        got_rd = resp_rdata_v[inst];
        got_e  = resp_err_v[inst];
        chk("rdata", got_rd, rd_exp);
        chk("err", 32'(got_e), 32'(e_exp));
        @(negedge clk);
        chk("valid_drop", 32'(resp_valid_v[inst]), 32'd0);
        chk("rdata_idle", resp_rdata_v[inst], 32'd0);
        chk("err_idle", 32'(resp_err_v[inst]), 32'd0);
        chk("busy_idle", 32'(busy_v[inst]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          e;
        int          last;
        int          nacc;
        int          r;
        logic [31:0] a;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_mode  = 3'd0;
        for (int i = 0; i < 4; i++) req_valid_v[i] = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", 32'(resp_valid_v[i]), 32'd0);
            chk("rst_rdata", resp_rdata_v[i], 32'd0);
            chk("rst_err", 32'(resp_err_v[i]), 32'd0);
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
            chk("rst_ready", 32'(req_ready_v[i]), 32'd1);
        end
        reset = 1'b0;

        // known contents for bytes 0..255 of every instance
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 64; w++)
                do_req(i, 1'b1, 32'(w * 4), $urandom, 3'b010, rd, e);

        // word store / load, LATENCY = 2
        do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, e);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", 32'(e), 32'd0);
        do_req(1, 1'b0, 32'h10, 32'd0, 3'b010, rd, e);
        chk("lw_10", rd, 32'hDEADBEEF);

        // lanes and extension
        do_req(1, 1'b1, 32'h20, 32'h80FF7F01, 3'b010, rd, e);
        do_req(1, 1'b0, 32'h21, 32'd0, 3'b000, rd, e);
        chk("lb_21", rd, 32'h0000007F);
        do_req(1, 1'b0, 32'h23, 32'd0, 3'b000, rd, e);
        chk("lb_23", rd, 32'hFFFFFF80);
        do_req(1, 1'b0, 32'h23, 32'd0, 3'b100, rd, e);
        chk("lbu_23", rd, 32'h00000080);
        do_req(1, 1'b0, 32'h22, 32'd0, 3'b001, rd, e);
        chk("lh_22", rd, 32'hFFFF80FF);
        do_req(1, 1'b0, 32'h22, 32'd0, 3'b101, rd, e);
        chk("lhu_22", rd, 32'h000080FF);
        do_req(1, 1'b1, 32'h22, 32'h123456AA, 3'b000, rd, e);
        do_req(1, 1'b0, 32'h20, 32'd0, 3'b010, rd, e);
        chk("sb_lw_20", rd, 32'h80AA7F01);

        // errors
        do_req(1, 1'b0, 32'h21, 32'd0, 3'b001, rd, e);
        chk("lh_mis_err", 32'(e), 32'd1);
        chk("lh_mis_rd", rd, 32'd0);
        do_req(1, 1'b1, 32'h22, 32'h55555555, 3'b010, rd, e);
        chk("sw_mis_err", 32'(e), 32'd1);
        do_req(1, 1'b0, 32'h20, 32'd0, 3'b010, rd, e);
        chk("sw_mis_nowr", rd, 32'h80AA7F01);
        do_req(1, 1'b0, 32'h20, 32'd0, 3'b011, rd, e);
        chk("size3_err", 32'(e), 32'd1);
        do_req(1, 1'b0, 32'h1000, 32'd0, 3'b010, rd, e);
        chk("range_err", 32'(e), 32'd1);

        // LATENCY = 1 (latency checked inside do_req)
        do_req(0, 1'b1, 32'h40, 32'hA5A5F00F, 3'b010, rd, e);
        do_req(0, 1'b0, 32'h41, 32'd0, 3'b000, rd, e);
        chk("l1_lb_41", rd, 32'hFFFFFFF0);

        // LATENCY = 4 with req_valid held high
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_mode  = 3'b010;
        req_valid_v[3] = 1'b1;
        last = -1;
        nacc = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (req_ready_v[3]) begin
                if (last >= 0) chk("accept_period", 32'(cyc - last), 32'd5);
                last = cyc;
                nacc++;
            end
            chk("ready_vs_busy", 32'(req_ready_v[3]), 32'(!busy_v[3]));
            @(negedge clk);
        end
        req_valid_v[3] = 1'b0;
        chk("accept_count", 32'(nacc), 32'd5);
        for (int k = 0; k < 10 && busy_v[3]; k++) @(negedge clk);
        chk("l4_idle", 32'(busy_v[3]), 32'd0);

        // reset one cycle after accept, LATENCY = 3
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_mode  = 3'b010;
        req_valid_v[2] = 1'b1;
        @(posedge clk);
        #1 req_valid_v[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rst_mid_busy", 32'(busy_v[2]), 32'd0);
            chk("rst_mid_valid", 32'(resp_valid_v[2]), 32'd0);
            @(negedge clk);
        end
        do_req(2, 1'b0, 32'h30, 32'd0, 3'b010, rd, e);

        // reset on the commit edge, LATENCY = 2
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h34;
        req_wdata = 32'hCAFEF00D;
        req_mode  = 3'b010;
        req_valid_v[1] = 1'b1;
        @(posedge clk);
        #1 req_valid_v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstc_valid", 32'(resp_valid_v[1]), 32'd0);
        chk("rstc_rdata", resp_rdata_v[1], 32'd0);
        chk("rstc_err", 32'(resp_err_v[1]), 32'd0);
        chk("rstc_busy", 32'(busy_v[1]), 32'd0);
        do_req(1, 1'b0, 32'h34, 32'd0, 3'b010, rd, e);

        // reset coinciding with accept/commit edge, LATENCY = 1
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h38;
        req_wdata = 32'h0BADF00D;
        req_mode  = 3'b010;
        req_valid_v[0] = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid_v[0] = 1'b0;
        chk("rsta_valid", 32'(resp_valid_v[0]), 32'd0);
        chk("rsta_busy", 32'(busy_v[0]), 32'd0);
        do_req(0, 1'b0, 32'h38, 32'd0, 3'b010, rd, e);

        // randomized traffic on every instance
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       a = 32'($urandom_range(0, 255));
                else if (r == 7) a = 32'h1000 | 32'($urandom_range(0, 255));
                else             a = $urandom;
                do_req(i, 1'($urandom_range(0, 1)), a, $urandom,
                       3'($urandom_range(0, 7)), rd, e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
